// File: rtl/csr_mtrap_unit.sv
// Machine-mode CSR file and trap sequencer sitting in EX beside the ALU.
// Holds the M-mode trap CSRs, the 64-bit cycle/instret/time counters and the
// prioritised trap/interrupt selection that redirects fetch.
module csr_mtrap_unit #(
    parameter int          XLEN        = 64,
    parameter int unsigned HART_ID     = 0,
    parameter int          MTIME_DIV   = 1,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [XLEN-1:0] pc,
    input  logic            retire,
    input  logic [3:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            ecall,
    input  logic            ebreak,
    input  logic            mret,
    input  logic            irq_ext,
    input  logic            irq_soft,
    output logic            except_en,
    output logic [XLEN-1:0] new_pc,
    output logic            mie_gbl
);

    localparam bit              IS32   = (XLEN == 32);
    localparam logic [1:0]      MXL    = IS32 ? 2'b01 : 2'b10;
    localparam logic [XLEN-1:0] MISA_V = {MXL, {(XLEN-11){1'b0}}, 9'h100};

    // Architectural state
    logic            mstat_mie, mstat_mpie, msip;
    logic [11:0]     mie_r;
    logic [XLEN-1:0] mtvec_r, mscratch, mepc, mcause, mtval;
    logic [63:0]     mcycle, minstret, mtime, mtimecmp;
    logic [7:0]      presc;

    // Decode / datapath nets
    logic            access, we, impl, illegal, csr_wr, tick;
    logic            mtip, msip_eff, mei_p, msi_p, mti_p;
    logic            trap, irq, do_mret;
    logic [3:0]      cause;
    logic [XLEN-1:0] old, wval, base;
    logic [63:0]     wval64;

    // Replace the low word of a 64-bit counter (whole counter when XLEN=64)
    function automatic logic [63:0] cnt_lo(input logic [63:0] cur, input logic [63:0] v);
        cnt_lo = IS32 ? {cur[63:32], v[31:0]} : v;
    endfunction

    // Replace the high word of a 64-bit counter (XLEN=32 only)
    function automatic logic [63:0] cnt_hi(input logic [63:0] cur, input logic [63:0] v);
        cnt_hi = {v[31:0], cur[31:0]};
    endfunction

    assign access   = |csr_op;
    assign we       = csr_op[3];
    assign mtip     = (mtime >= mtimecmp);
    assign msip_eff = msip | irq_soft;
    assign mei_p    = mstat_mie & mie_r[11] & irq_ext;
    assign msi_p    = mstat_mie & mie_r[3] & msip_eff;
    assign mti_p    = mstat_mie & mie_r[7] & mtip;
    assign mie_gbl  = mstat_mie;
    assign tick     = (presc == 8'(MTIME_DIV - 1));
    assign base     = mtvec_r & ~XLEN'(3);

    // CSR read mux and implemented-address decode
    always_comb begin
        old  = '0;
        impl = 1'b1;
        case (csr_addr)
            12'h300: old = XLEN'({2'b11, 3'b000, mstat_mpie, 3'b000, mstat_mie, 3'b000});
            12'h301: old = MISA_V;
            12'h304: old = XLEN'(mie_r);
            12'h305: old = mtvec_r;
            12'h340: old = mscratch;
            12'h341: old = mepc;
            12'h342: old = mcause;
            12'h343: old = mtval;
            12'h344: old = XLEN'({irq_ext, 3'b000, mtip, 3'b000, msip_eff, 3'b000});
            12'hB00: old = mcycle[XLEN-1:0];
            12'hB02: old = minstret[XLEN-1:0];
            12'h7C0: old = mtimecmp[XLEN-1:0];
            12'h7C1: old = mtime[XLEN-1:0];
            12'hB80: begin old = XLEN'(mcycle[63:32]);   impl = IS32; end
            12'hB82: begin old = XLEN'(minstret[63:32]); impl = IS32; end
            12'h7C2: begin old = XLEN'(mtimecmp[63:32]); impl = IS32; end
            12'h7C3: begin old = XLEN'(mtime[63:32]);    impl = IS32; end
            12'hF11, 12'hF12, 12'hF13: old = '0;
            12'hF14: old = XLEN'(HART_ID);
            default: impl = 1'b0;
        endcase
    end

    assign csr_rdata = (access && impl) ? old : '0;
    assign illegal   = access && (!impl || (we && (csr_addr[11:10] == 2'b11 ||
                                  csr_addr == 12'h7C1 || csr_addr == 12'h7C3)));

    // Read-modify-write value for csrrw / csrrs / csrrc
    always_comb begin
        if (csr_op[2])      wval = csr_wdata;
        else if (csr_op[1]) wval = csr_rdata | csr_wdata;
        else if (csr_op[0]) wval = csr_rdata & ~csr_wdata;
        else                wval = csr_rdata;
        wval64 = 64'(wval);
    end

    // Trap selection in priority order; nothing is taken while stalled
    always_comb begin
        trap    = 1'b0;
        irq     = 1'b0;
        cause   = 4'd0;
        do_mret = 1'b0;
        if (!stall) begin
            if (illegal)      begin trap = 1'b1; cause = 4'd2;  end
            else if (ecall)   begin trap = 1'b1; cause = 4'd11; end
            else if (ebreak)  begin trap = 1'b1; cause = 4'd3;  end
            else if (mret)    begin do_mret = 1'b1;             end
            else if (mei_p)   begin trap = 1'b1; irq = 1'b1; cause = 4'd11; end
            else if (msi_p)   begin trap = 1'b1; irq = 1'b1; cause = 4'd3;  end
            else if (mti_p)   begin trap = 1'b1; irq = 1'b1; cause = 4'd7;  end
        end
    end

    assign except_en = trap | do_mret;
    assign csr_wr    = access && we && !illegal && !stall && !except_en;

    // Redirect target: mepc for mret, else mtvec base (vectored for interrupts)
    always_comb begin
        if (do_mret)
            new_pc = mepc;
        else if (VECTORED_EN && mtvec_r[0] && irq)
            new_pc = base + XLEN'({cause, 2'b00});
        else
            new_pc = base;
    end

    // Free-running counters; a software write in the same cycle wins over the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            presc    <= '0;
        end else begin
            mcycle <= mcycle + 64'd1;
            if (retire && !stall && !except_en)
                minstret <= minstret + 64'd1;
            if (tick) begin
                presc <= '0;
                mtime <= mtime + 64'd1;
            end else begin
                presc <= presc + 8'd1;
            end
            if (csr_wr) begin
                case (csr_addr)
                    12'hB00: mcycle   <= cnt_lo(mcycle, wval64);
                    12'hB80: mcycle   <= cnt_hi(mcycle, wval64);
                    12'hB02: minstret <= cnt_lo(minstret, wval64);
                    12'hB82: minstret <= cnt_hi(minstret, wval64);
                    12'h7C0: mtimecmp <= cnt_lo(mtimecmp, wval64);
                    12'h7C2: mtimecmp <= cnt_hi(mtimecmp, wval64);
                    default: ;
                endcase
            end
        end
    end

    // Trap entry, mret return and software writes to the trap CSRs
    always_ff @(posedge clk) begin
        if (rst) begin
            mstat_mie  <= 1'b0;
            mstat_mpie <= 1'b0;
            msip       <= 1'b0;
            mie_r      <= '0;
            mtvec_r    <= '0;
            mscratch   <= '0;
            mepc       <= '0;
            mcause     <= '0;
            mtval      <= '0;
        end else if (trap) begin
            mepc       <= pc & ~XLEN'(3);
            mcause     <= {irq, {(XLEN-5){1'b0}}, cause};
            mtval      <= '0;
            mstat_mpie <= mstat_mie;
            mstat_mie  <= 1'b0;
        end else if (do_mret) begin
            mstat_mie  <= mstat_mpie;
            mstat_mpie <= 1'b1;
        end else if (csr_wr) begin
            case (csr_addr)
                12'h300: begin mstat_mie <= wval[3]; mstat_mpie <= wval[7]; end
                12'h304: mie_r    <= wval[11:0] & 12'h888;
                12'h305: mtvec_r  <= {wval[XLEN-1:2], 1'b0, VECTORED_EN & wval[0]};
                12'h340: mscratch <= wval;
                12'h341: mepc     <= wval & ~XLEN'(3);
                12'h342: mcause   <= wval;
                12'h343: mtval    <= wval;
                12'h344: msip     <= wval[3];
                default: ;
            endcase
        end
    end

endmodule
